// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transfer scheduler: state encoding,
// default parameter values and an index-width helper.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_ABORT   = 3'd4,
    S_GAP     = 3'd5
  } spi_sched_state_e;

  localparam int          DEF_N_REQ       = 4;
  localparam int          DEF_DATA_W      = 32;
  localparam int          DEF_TO_W        = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 32'h0000_FFFF;

  // Width of a requester index; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_dff.sv
// Resettable register with a configurable reset value.
module spi_dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping.
// Returns a one-hot grant, its index and whether any request was present.
module spi_rr_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output gets a default first so no path leaves a value
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    // Walk from the farthest offset down so the nearest candidate wins last.
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
    if (valid) grant = N_REQ'(1) << idx;
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// Shares one SPI master core between N_REQ requesters: round-robin grant,
// go pulse, bounded wait for completion, RX capture and done/err return.
module spi_xfer_sched
  import spi_pkg::*;
#(
  parameter int          N_REQ       = DEF_N_REQ,
  parameter int          DATA_W      = DEF_DATA_W,
  parameter int          TO_W        = DEF_TO_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_txd,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        err,
  output logic [DATA_W-1:0]       rxd,
  output logic [DATA_W-1:0]       core_txd,
  output logic [N_REQ-1:0]        core_ss,
  output logic                    core_go,
  input  logic                    core_bsy_clr,
  input  logic [DATA_W-1:0]       core_rxd,
  output logic                    core_rd_en
);

  localparam int              IDX_W   = idx_width(N_REQ);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  spi_sched_state_e state_q, state_d;
  logic [2:0]       state_raw;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q;
  logic [N_REQ-1:0] owner_oh_q;
  logic [TO_W-1:0]  cnt_q;
  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic             grant_now;

  spi_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  spi_dff #(.W(3), .RST_VAL(S_IDLE)) u_state_reg (
    .clk (pclk), .rst_n (presetn), .d (state_d), .q (state_raw)
  );
  assign state_q = spi_sched_state_e'(state_raw);

  // ptr resets to the last requester so requester 0 is first in line.
  spi_dff #(.W(IDX_W), .RST_VAL(IDX_W'(N_REQ - 1))) u_ptr_reg (
    .clk (pclk), .rst_n (presetn), .d (ptr_d), .q (ptr_q)
  );

  assign grant_now = (state_q == S_IDLE) && arb_valid;
  assign ptr_d     = (state_q == S_CAPTURE || state_q == S_ABORT) ? owner_q : ptr_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:             if (arb_valid) state_d = S_START;
      S_START:            state_d = S_WAIT;
      // A completion seen on the last allowed cycle still counts as success.
      S_WAIT: begin
        if (core_bsy_clr)          state_d = S_CAPTURE;
        else if (cnt_q == TO_LAST) state_d = S_ABORT;
      end
      S_CAPTURE, S_ABORT: state_d = S_GAP;
      S_GAP:              state_d = S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      owner_q    <= '0;
      owner_oh_q <= '0;
      core_txd   <= '0;
      cnt_q      <= '0;
      rxd        <= '0;
    end else begin
      if (grant_now) begin
        owner_q    <= arb_idx;
        owner_oh_q <= arb_grant;
        core_txd   <= req_txd[int'(arb_idx)*DATA_W +: DATA_W];
      end
      if (state_q == S_START)     cnt_q <= '0;
      else if (state_q == S_WAIT) cnt_q <= cnt_q + TO_W'(1);
      // Capture on the sampling edge so rxd is already valid alongside done.
      if (state_q == S_WAIT && core_bsy_clr) rxd <= core_rxd;
    end
  end

  always_comb begin
    gnt        = '0;
    done       = '0;
    err        = '0;
    core_go    = 1'b0;
    core_rd_en = 1'b0;
    unique case (state_q)
      S_START: begin
        gnt     = owner_oh_q;
        core_go = 1'b1;
      end
      S_WAIT:  gnt = owner_oh_q;
      S_CAPTURE: begin
        gnt        = owner_oh_q;
        done       = owner_oh_q;
        core_rd_en = 1'b1;
      end
      S_ABORT: begin
        gnt = owner_oh_q;
        err = owner_oh_q;
      end
      default: ;
    endcase
  end

  assign core_ss = gnt;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Randomized bench for spi_xfer_sched against a transaction-timeline model:
// each grant is planned as start/response/end cycles from the rules.
module tb_spi_xfer_sched;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int T  = 12;

  logic            pclk = 1'b0;
  logic            presetn = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_txd = '0;
  logic [N-1:0]    gnt, done, err, core_ss;
  logic [DW-1:0]   rxd, core_txd;
  logic            core_go, core_rd_en;
  logic            core_bsy_clr = 1'b0;
  logic [DW-1:0]   core_rxd = '0;

  spi_xfer_sched #(.N_REQ(N), .DATA_W(DW), .TO_W(16), .TIMEOUT_CYC(T)) dut (
    .pclk         (pclk),
    .presetn      (presetn),
    .req          (req),
    .req_txd      (req_txd),
    .gnt          (gnt),
    .done         (done),
    .err          (err),
    .rxd          (rxd),
    .core_txd     (core_txd),
    .core_ss      (core_ss),
    .core_go      (core_go),
    .core_bsy_clr (core_bsy_clr),
    .core_rxd     (core_rxd),
    .core_rd_en   (core_rd_en)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Model: current/last planned transfer on an absolute cycle timeline.
  int            cyc = 0;
  bit            m_active = 1'b0, m_ok = 1'b0;
  int            m_s, m_r, m_e, m_w;
  int            m_ptr = N - 1;
  int            m_idle_from = 0;
  logic [DW-1:0] m_txd, m_rdata;
  logic [DW-1:0] exp_txd = '0, exp_rxd = '0;

  // Stimulus state and knobs.
  logic [N-1:0]  req_v = '0;
  logic [DW-1:0] txd_v [N];
  int            add_pct = 0, drop_pct = 0, to_pct = 0, delay_fix = -1;
  bit            hold_all = 1'b0, rdata_fix_en = 1'b0, txd0_fix_en = 1'b0;
  logic [DW-1:0] rdata_fix = '0, txd0_fix = '0;

  // Observations of the DUT used by directed checks.
  int go_log[$];
  int done_cnt [N];
  int err_cnt  [N];

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic int oh_index(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_logs();
    go_log.delete();
    for (int i = 0; i < N; i++) begin
      done_cnt[i] = 0;
      err_cnt[i]  = 0;
    end
  endtask

  task automatic cycle();
    bit           in_xfer, at_end;
    logic [N-1:0] oh;
    int           d, w;
    @(negedge pclk);
    cyc++;
    if (m_active && cyc == m_s)         exp_txd = m_txd;
    if (m_active && m_ok && cyc == m_e) exp_rxd = m_rdata;
    in_xfer = m_active && cyc >= m_s && cyc <= m_e;
    at_end  = m_active && cyc == m_e;
    oh = '0;
    if (in_xfer) oh[m_w] = 1'b1;

    check("gnt",        gnt,        oh);
    check("core_ss",    core_ss,    oh);
    check("core_go",    core_go,    m_active && cyc == m_s);
    check("done",       done,       (at_end && m_ok)  ? oh : '0);
    check("err",        err,        (at_end && !m_ok) ? oh : '0);
    check("core_rd_en", core_rd_en, at_end && m_ok);
    check("core_txd",   core_txd,   exp_txd);
    check("rxd",        rxd,        exp_rxd);

    if (core_go) go_log.push_back(oh_index(core_ss));
    for (int i = 0; i < N; i++) begin
      done_cnt[i] += int'(done[i]);
      err_cnt[i]  += int'(err[i]);
    end

    if (at_end) begin
      m_ptr = m_w;
      req_v[m_w] = 1'b0;
    end

    if (hold_all) req_v = '1;
    else
      for (int i = 0; i < N; i++)
        if (!req_v[i] && $urandom_range(99) < add_pct) req_v[i] = 1'b1;
    if (in_xfer && !at_end && cyc > m_s && $urandom_range(99) < drop_pct) req_v[m_w] = 1'b0;

    for (int i = 0; i < N; i++) txd_v[i] = $urandom;
    if (txd0_fix_en) txd_v[0] = txd0_fix;
    req = req_v;
    for (int i = 0; i < N; i++) req_txd[i*DW +: DW] = txd_v[i];

    if (cyc >= m_idle_from && req_v != '0) begin
      w = pick(req_v, m_ptr);
      if (delay_fix >= 0)                   d = delay_fix;
      else if ($urandom_range(99) < to_pct) d = 0;
      else                                  d = $urandom_range(T, 1);
      m_active = 1'b1;
      m_w      = w;
      m_s      = cyc + 1;
      m_txd    = txd_v[w];
      m_rdata  = rdata_fix_en ? rdata_fix : DW'($urandom);
      m_ok     = (d > 0);
      m_r      = m_s + d;
      m_e      = m_ok ? m_r + 1 : m_s + 1 + T;
      m_idle_from = m_e + 2;
    end

    // Core model: finished level from the response cycle until acknowledged.
    if (m_active && m_ok && cyc >= m_r && cyc <= m_e) begin
      core_bsy_clr = 1'b1;
      core_rxd     = (cyc == m_r) ? m_rdata : ~m_rdata;
    end else begin
      core_bsy_clr = 1'b0;
      core_rxd     = $urandom;
    end
  endtask

  task automatic do_reset();
    @(posedge pclk);
    #2;
    presetn = 1'b0;
    #1;
    check("rst_gnt",        gnt,        '0);
    check("rst_core_ss",    core_ss,    '0);
    check("rst_core_go",    core_go,    1'b0);
    check("rst_done",       done,       '0);
    check("rst_err",        err,        '0);
    check("rst_core_rd_en", core_rd_en, 1'b0);
    check("rst_core_txd",   core_txd,   '0);
    check("rst_rxd",        rxd,        '0);
    req_v = '0;
    req = '0;
    core_bsy_clr = 1'b0;
    repeat (2) @(negedge pclk);
    m_active = 1'b0;
    m_ptr = N - 1;
    m_idle_from = 0;
    exp_txd = '0;
    exp_rxd = '0;
    presetn = 1'b1;
  endtask

  initial begin
    clear_logs();
    do_reset();

    // Single request from requester 0 with a 10-cycle core response.
    delay_fix = 10;
    rdata_fix_en = 1'b1;  rdata_fix = 32'h1234_5678;
    txd0_fix_en  = 1'b1;  txd0_fix  = 32'hA5A5_0001;
    req_v = 4'b0001;
    repeat (25) cycle();
    check("single_rxd",      rxd, 32'h1234_5678);
    check("single_txd",      core_txd, 32'hA5A5_0001);
    check("single_go_count", go_log.size(), 1);
    check("single_go_owner", (go_log.size() > 0) ? go_log[0] : -1, 0);
    check("single_done0",    done_cnt[0], 1);
    txd0_fix_en = 1'b0;
    rdata_fix_en = 1'b0;

    // Fairness from reset with every requester continuously requesting.
    do_reset();
    clear_logs();
    delay_fix = -1;
    hold_all = 1'b1;
    for (int i = 0; i < 400 && go_log.size() < 5; i++) cycle();
    check("fair_go_count", go_log.size() >= 5, 1'b1);
    for (int i = 0; i < 5; i++)
      check($sformatf("fair_order%0d", i), (go_log.size() > i) ? go_log[i] : -1, i % N);
    for (int i = 0; i < N; i++)
      check($sformatf("fair_done%0d", i), done_cnt[i], 1);
    hold_all = 1'b0;
    req_v = '0;
    repeat (20) cycle();

    // Timeouts on two requesters back to back.
    clear_logs();
    delay_fix = 0;
    req_v = 4'b1100;
    repeat (45) cycle();
    check("to_err2",   err_cnt[2], 1);
    check("to_err3",   err_cnt[3], 1);
    check("to_done",   done_cnt[2] + done_cnt[3], 0);
    check("to_served", go_log.size(), 2);

    // Completion on the final allowed wait cycle wins over the timeout.
    clear_logs();
    delay_fix = T;
    rdata_fix_en = 1'b1;  rdata_fix = 32'hC0DE_0010;
    req_v = 4'b0001;
    repeat (25) cycle();
    check("simul_done", done_cnt[0], 1);
    check("simul_err",  err_cnt[0], 0);
    check("simul_rxd",  rxd, 32'hC0DE_0010);
    rdata_fix_en = 1'b0;

    // Owner withdraws its request while waiting; the transfer still finishes.
    clear_logs();
    delay_fix = -1;  to_pct = 0;  drop_pct = 100;
    req_v = 4'b1000;
    repeat (25) cycle();
    check("drop_done", done_cnt[3], 1);
    check("drop_err",  err_cnt[3], 0);
    drop_pct = 0;

    // Reset in the middle of a wait, then requester 1 alone.
    delay_fix = 0;
    req_v = 4'b0001;
    repeat (5) cycle();
    do_reset();
    clear_logs();
    delay_fix = -1;
    req_v = 4'b0010;
    repeat (20) cycle();
    check("rst_first_owner", (go_log.size() > 0) ? go_log[0] : -1, 1);
    check("rst_done1",       done_cnt[1], 1);
    check("rst_no_done0",    done_cnt[0] + err_cnt[0], 0);

    // Random traffic.
    add_pct = 15;  drop_pct = 5;  to_pct = 15;  delay_fix = -1;
    repeat (3000) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
